// File: rtl/fft_mem_pkg.sv
// Shared definitions for the FFT working-memory arbiter.
// Holds requester indices, default memory geometry, the lock-state
// encoding and a small one-hot decode helper.
package fft_mem_pkg;

  localparam int N_REQ      = 3;
  localparam int REQ_LOAD   = 0;
  localparam int REQ_BFLY   = 1;
  localparam int REQ_UNLOAD = 2;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int ADDR_WIDTH_DEF = 12;
  localparam int MEM_DEPTH_DEF  = 2049;
  localparam int LOCK_MAX_DEF   = 4;

  typedef enum logic {
    LK_UNLOCKED = 1'b0,
    LK_LOCKED   = 1'b1
  } lock_state_e;

  function automatic logic [N_REQ-1:0] onehot3(input logic [1:0] idx);
    logic [N_REQ-1:0] v;
    v = '0;
    case (idx)
      2'(REQ_LOAD):   v = 3'b001;
      2'(REQ_BFLY):   v = 3'b010;
      2'(REQ_UNLOAD): v = 3'b100;
      default:        v = '0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/rr_arb3.sv
// Combinational three-way round-robin pick.
// Ports:
//   req    - request vector
//   rr_ptr - index granted most recently (lowest priority this cycle)
//   gnt    - one-hot winner, zero when nothing requests
//   idx    - winner index (0 when nothing requests)
//   any    - at least one request present
module rr_arb3
  import fft_mem_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] rr_ptr,
  output logic [2:0] gnt,
  output logic [1:0] idx,
  output logic       any
);

  logic [1:0] ord [3];

  always_comb begin
    case (rr_ptr)
      2'd0:    ord = '{2'd1, 2'd2, 2'd0};
      2'd1:    ord = '{2'd2, 2'd0, 2'd1};
      default: ord = '{2'd0, 2'd1, 2'd2};
    endcase
    idx = 2'd0;
    any = 1'b0;
    // Scan from lowest to highest priority so the highest-priority hit wins.
    for (int i = 2; i >= 0; i--) begin
      if (req[ord[i]]) begin
        idx = ord[i];
        any = 1'b1;
      end
    end
    gnt = any ? onehot3(idx) : 3'b000;
  end

endmodule

// File: rtl/mem_arb.sv
// Round-robin arbiter sharing one single-port FFT working memory between
// the loader (0), butterfly engine (1) and unloader (2), with a bounded
// lock for read/modify/write sequences and a sticky out-of-range flag.
// Ports:
//   clk, rst                 - clock, async active-high reset
//   req/we/lock              - per-requester request, write select, lock hold
//   addr/wdata               - packed per-requester address and write data
//   gnt                      - one-hot grant, same cycle as the request
//   rvalid/rdata             - read return one cycle after grant
//   err                      - sticky out-of-range access flag
//   mem_addr/mem_wr_ena/mem_data_wr/mem_data_rd - memory port
//
// Lock FSM:
//   state       | meaning
//   LK_UNLOCKED | plain round-robin arbitration
//   LK_LOCKED   | lock_owner keeps the grant while it requests, up to LOCK_MAX grants
module mem_arb
  import fft_mem_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int MEM_DEPTH  = MEM_DEPTH_DEF,
  parameter int LOCK_MAX   = LOCK_MAX_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [2:0]              req,
  input  logic [2:0]              we,
  input  logic [2:0]              lock,
  input  logic [3*ADDR_WIDTH-1:0] addr,
  input  logic [3*DATA_WIDTH-1:0] wdata,
  output logic [2:0]              gnt,
  output logic [2:0]              rvalid,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    err,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic                    mem_wr_ena,
  output logic [DATA_WIDTH-1:0]   mem_data_wr,
  input  logic [DATA_WIDTH-1:0]   mem_data_rd
);

  localparam int CW = $clog2(LOCK_MAX) + 1;
  localparam logic [CW-1:0]         CNT_LAST = CW'(LOCK_MAX - 1);
  localparam logic [ADDR_WIDTH:0]   DEPTH_L  = (ADDR_WIDTH + 1)'(MEM_DEPTH);

  lock_state_e     lock_state;
  logic [1:0]      lock_owner;
  logic [CW-1:0]   lock_cnt;
  logic [1:0]      rr_ptr;

  logic [2:0]            arb_gnt;
  logic [1:0]            arb_idx;
  logic                  arb_any;
  logic                  locked_hold;
  logic [1:0]            g_idx;
  logic                  g_any;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic                  sel_we;
  logic                  sel_lock;
  logic                  in_range;
  logic                  take;

  rr_arb3 u_rr (
    .req    (req),
    .rr_ptr (rr_ptr),
    .gnt    (arb_gnt),
    .idx    (arb_idx),
    .any    (arb_any)
  );

  always_comb begin
    locked_hold = (lock_state == LK_LOCKED) && req[lock_owner];
    g_idx       = locked_hold ? lock_owner : arb_idx;
    g_any       = locked_hold || arb_any;
    case (g_idx)
      2'd1: begin
        sel_addr  = addr[ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata = wdata[DATA_WIDTH +: DATA_WIDTH];
      end
      2'd2: begin
        sel_addr  = addr[2*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata = wdata[2*DATA_WIDTH +: DATA_WIDTH];
      end
      default: begin
        sel_addr  = addr[0 +: ADDR_WIDTH];
        sel_wdata = wdata[0 +: DATA_WIDTH];
      end
    endcase
    sel_we   = we[g_idx];
    sel_lock = lock[g_idx];
    in_range = {1'b0, sel_addr} < DEPTH_L;
    // Outputs are forced quiet while reset is held, not just after the edge.
    take        = g_any && !rst;
    gnt         = take ? onehot3(g_idx) : 3'b000;
    mem_wr_ena  = take && in_range && sel_we;
    mem_addr    = (take && in_range) ? sel_addr  : '0;
    mem_data_wr = (take && in_range) ? sel_wdata : '0;
  end

  assign rdata = mem_data_rd;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr     <= 2'd2;
      lock_state <= LK_UNLOCKED;
      lock_owner <= 2'd0;
      lock_cnt   <= '0;
      rvalid     <= 3'b000;
      err        <= 1'b0;
    end else begin
      rvalid <= (g_any && in_range && !sel_we) ? onehot3(g_idx) : 3'b000;
      if (g_any && !in_range)
        err <= 1'b1;
      if (g_any)
        rr_ptr <= g_idx;
      case (lock_state)
        LK_UNLOCKED: begin
          if (g_any && sel_lock && (LOCK_MAX > 1)) begin
            lock_state <= LK_LOCKED;
            lock_owner <= g_idx;
            lock_cnt   <= CW'(1);
          end
        end
        default: begin
          // Owner dropping its request, dropping lock, or hitting the grant
          // limit all release; the grant in that cycle still goes through.
          if (locked_hold && sel_lock && (lock_cnt < CNT_LAST)) begin
            lock_cnt <= lock_cnt + CW'(1);
          end else begin
            lock_state <= LK_UNLOCKED;
            lock_cnt   <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arb.sv
module tb_mem_arb;

  localparam int AW    = 12;
  localparam int DW    = 32;
  localparam int DEPTH = 2049;
  localparam int LMAX  = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [2:0]      req, we, lock;
  logic [3*AW-1:0] addr;
  logic [3*DW-1:0] wdata;
  logic [2:0]      gnt, rvalid;
  logic [DW-1:0]   rdata;
  logic            err;
  logic [AW-1:0]   mem_addr;
  logic            mem_wr_ena;
  logic [DW-1:0]   mem_data_wr;
  logic [DW-1:0]   mem_data_rd;

  mem_arb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_DEPTH(DEPTH), .LOCK_MAX(LMAX)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .lock(lock), .addr(addr), .wdata(wdata),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .err(err),
    .mem_addr(mem_addr), .mem_wr_ena(mem_wr_ena), .mem_data_wr(mem_data_wr),
    .mem_data_rd(mem_data_rd)
  );

  always #5 clk = ~clk;

  // Environment memory: registered read, write-or-read each cycle.
  logic [DW-1:0] bmem [0:4095];
  always @(posedge clk) begin
    if (mem_wr_ena) bmem[mem_addr] <= mem_data_wr;
    else            mem_data_rd    <= bmem[mem_addr];
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: scan order, consecutive-grant lock run, shadow memory.
  logic [DW-1:0] shadow [0:4095];
  int            m_last  = 2;
  int            m_owner = -1;
  int            m_run   = 0;
  logic          m_err   = 1'b0;
  logic [2:0]    m_rv    = 3'b000;
  logic [DW-1:0] m_rd    = '0;

  always @(negedge clk) begin : model
    int            e;
    bit            dropped;
    logic [2:0]    exp_g;
    logic [AW-1:0] a;
    bit            inr;
    if (rst) begin
      chk("rst_gnt", gnt, 0);
      chk("rst_rvalid", rvalid, 0);
      chk("rst_err", err, 0);
      chk("rst_wr_ena", mem_wr_ena, 0);
      chk("rst_mem_addr", mem_addr, 0);
      m_last = 2; m_owner = -1; m_run = 0; m_err = 1'b0; m_rv = 3'b000;
    end else begin
      e = -1;
      if (m_owner >= 0 && req[m_owner]) e = m_owner;
      else
        for (int s = 1; s <= 3; s++)
          if (e < 0 && req[(m_last + s) % 3]) e = (m_last + s) % 3;
      exp_g = (e < 0) ? 3'b000 : (3'(1) << e);
      chk("gnt", gnt, exp_g);
      chk("rvalid", rvalid, m_rv);
      if (m_rv != 3'b000) chk("rdata", rdata, m_rd);
      chk("err", err, m_err);
      m_rv = 3'b000;
      dropped = (m_owner >= 0) && (e != m_owner);
      if (dropped) m_owner = -1;
      if (e >= 0) begin
        a   = addr[e*AW +: AW];
        inr = (int'(a) < DEPTH);
        chk("wr_ena", mem_wr_ena, inr && we[e]);
        chk("mem_addr", mem_addr, inr ? a : '0);
        if (inr && we[e]) chk("mem_wdata", mem_data_wr, wdata[e*DW +: DW]);
        if (!inr) m_err = 1'b1;
        else if (we[e]) shadow[a] = wdata[e*DW +: DW];
        else begin
          m_rv = 3'(1) << e;
          m_rd = shadow[a];
        end
        m_last = e;
        if (m_owner == e) begin
          m_run++;
          if (!lock[e] || m_run >= LMAX) m_owner = -1;
        end else if (!dropped && lock[e]) begin
          m_owner = e;
          m_run   = 1;
        end
      end else begin
        chk("idle_wr_ena", mem_wr_ena, 0);
      end
    end
  end

  logic [2:0] g_seen;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic look();
    @(negedge clk); #1;
    g_seen = gnt;
  endtask

  task automatic set_rd(input int k, input logic [AW-1:0] a);
    addr[k*AW +: AW] = a;
    we[k] = 1'b0;
  endtask

  task automatic set_wr(input int k, input logic [AW-1:0] a, input logic [DW-1:0] d);
    addr[k*AW +: AW]  = a;
    wdata[k*DW +: DW] = d;
    we[k] = 1'b1;
  endtask

  logic [2:0] t1g [3];
  logic [2:0] t3g [6];

  initial begin
    for (int i = 0; i < 4096; i++) begin
      bmem[i]   = 32'hA000_0000 + i;
      shadow[i] = 32'hA000_0000 + i;
    end
    t1g = '{3'b001, 3'b010, 3'b100};
    t3g = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b100, 3'b001};
    req = 3'b111; we = 3'b000; lock = 3'b000; addr = '0; wdata = '0;
    set_rd(0, 12'd5); set_rd(1, 12'd6); set_rd(2, 12'd7);

    // Reset state with all requests pending.
    repeat (2) begin
      look();
      chk("reset_gnt", gnt, 3'b000);
      chk("reset_rvalid", rvalid, 3'b000);
      chk("reset_err", err, 1'b0);
    end
    @(posedge clk); #1;
    rst = 1'b0;

    // Three simultaneous reads: requester 0 first, then rotation.
    for (int c = 0; c < 3; c++) begin
      look();
      chk("t1_gnt", g_seen, t1g[c]);
      if (c > 0) begin
        chk("t1_rvalid", rvalid, t1g[c-1]);
        chk("t1_rdata", rdata, 32'hA000_0005 + c - 1);
      end
      tick();
      req = req & ~g_seen;
    end
    look();
    chk("t1_rvalid_last", rvalid, 3'b100);
    chk("t1_rdata_last", rdata, 32'hA000_0007);
    tick();

    // Write then read-back of the same address on the next cycle.
    set_wr(0, 12'd100, 32'hDEAD_BEEF); req = 3'b001;
    look();
    chk("t2_wr_gnt", g_seen, 3'b001);
    chk("t2_wr_ena", mem_wr_ena, 1'b1);
    tick();
    req = 3'b000; set_rd(2, 12'd100); req = 3'b100;
    look();
    chk("t2_rd_gnt", g_seen, 3'b100);
    tick();
    req = 3'b000;
    look();
    chk("t2_rvalid", rvalid, 3'b100);
    chk("t2_rdata", rdata, 32'hDEAD_BEEF);
    tick();

    // Move the pointer to 0 so requester 1 wins next, then lock run.
    set_rd(0, 12'd10); req = 3'b001;
    look();
    tick();
    req = 3'b000;
    set_rd(1, 12'd11); set_rd(2, 12'd12);
    lock = 3'b010; req = 3'b111;
    for (int c = 0; c < 6; c++) begin
      look();
      chk("t3_gnt", g_seen, t3g[c]);
      tick();
      if (g_seen != 3'b010) req = req & ~g_seen;
    end
    req = 3'b000; lock = 3'b000;

    // Locked owner drops its request after two grants.
    lock = 3'b010; req = 3'b111;
    look(); chk("t4_gnt0", g_seen, 3'b010); tick();
    look(); chk("t4_gnt1", g_seen, 3'b010); tick();
    req[1] = 1'b0; lock = 3'b000;
    look(); chk("t4_gnt2", g_seen, 3'b100); tick();
    req = req & ~g_seen;
    look(); chk("t4_gnt3", g_seen, 3'b001); tick();
    req = 3'b000;

    // Out-of-range write, then the last valid address.
    set_wr(0, 12'd2049, 32'h1234_5678); req = 3'b001;
    look();
    chk("t5_oor_gnt", g_seen, 3'b001);
    chk("t5_oor_wr_ena", mem_wr_ena, 1'b0);
    tick();
    req = 3'b000;
    look();
    chk("t5_err_set", err, 1'b1);
    tick();
    set_rd(0, 12'd2048); req = 3'b001;
    look();
    chk("t5_edge_gnt", g_seen, 3'b001);
    tick();
    req = 3'b000;
    look();
    chk("t5_edge_rvalid", rvalid, 3'b001);
    chk("t5_edge_rdata", rdata, 32'hA000_0800);
    chk("t5_err_sticky", err, 1'b1);
    tick();

    // Reset while a read result is pending.
    set_rd(0, 12'd20); set_rd(1, 12'd21); set_rd(2, 12'd22); req = 3'b111;
    look();
    chk("t6_gnt", g_seen, 3'b010);
    tick();
    req = req & ~g_seen;
    chk("t6_rvalid_pending", rvalid, 3'b010);
    rst = 1'b1;
    #1;
    chk("t6_rst_rvalid", rvalid, 3'b000);
    chk("t6_rst_gnt", gnt, 3'b000);
    chk("t6_rst_err", err, 1'b0);
    tick();
    tick();
    rst = 1'b0; req = 3'b111;
    look();
    chk("t6_after_gnt", g_seen, 3'b001);
    tick();
    req = 3'b000;
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_arb.md
Name: mem_arb

Overview:
- Three-way round-robin arbiter sharing one single-port FFT working memory (1-cycle registered read, write-or-read per cycle) between the input loader (req 0), butterfly engine (req 1) and output unloader (req 2).
- Grants one requester per cycle and drives the memory port from that requester.
- Returns read data with a per-requester valid strobe.
- Supports a bounded lock so the butterfly can run read/modify/write sequences without interleaving.

Parameters:
- DATA_WIDTH, 32, memory word width
- ADDR_WIDTH, 12, memory address width
- MEM_DEPTH, 2049, number of valid words; addresses >= MEM_DEPTH are out of range
- LOCK_MAX, 4, maximum consecutive cycles one requester may hold a locked grant

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req  in  3  request per requester, held until granted
- we  in  3  1 = write, 0 = read, per requester
- lock  in  3  request to keep grant next cycle
- addr  in  3*ADDR_WIDTH  address, requester k at bits [k*ADDR_WIDTH +: ADDR_WIDTH]
- wdata  in  3*DATA_WIDTH  write data, same packing
- gnt  out  3  one-hot grant, same cycle as accepted request
- rvalid  out  3  read data valid for requester k
- rdata  out  DATA_WIDTH  shared read data
- err  out  1  sticky out-of-range flag
- mem_addr  out  ADDR_WIDTH  to memory addr
- mem_wr_ena  out  1  to memory wr_ena
- mem_data_wr  out  DATA_WIDTH  to memory data_wr
- mem_data_rd  in  DATA_WIDTH  from memory data_rd

Behaviour:
- Reset (async, rst=1):
  - Registers: rr_ptr=2 (requester 0 highest priority after reset), lock_owner=none, lock_cnt=0, rvalid=0, err=0.
  - Outputs: gnt=0, mem_wr_ena=0, mem_addr=0, mem_data_wr=0 while rst=1.
- Grant (combinational from req, rr_ptr, lock state):
  - Normal: first asserted req scanning rr_ptr+1, rr_ptr+2, rr_ptr (mod 3). No req: gnt=0, mem_wr_ena=0, mem_addr/mem_data_wr hold 0.
  - Locked: if lock_owner=k and req[k]=1, gnt=1<<k, ignoring others.
- rr_ptr update: on each grant, rr_ptr <= granted index.
- Lock state machine, states UNLOCKED / LOCKED(k):
  - UNLOCKED -> LOCKED(k) when k is granted with lock[k]=1; lock_cnt<=1.
  - LOCKED(k), granted again with lock[k]=1 and lock_cnt<LOCK_MAX-1: lock_cnt++.
  - LOCKED(k) -> UNLOCKED when req[k]=0, lock[k]=0 at grant, or lock_cnt reaches LOCK_MAX-1 at grant. The grant in that cycle still occurs; lock_cnt<=0.
  - Net effect: at most LOCK_MAX back-to-back grants to one owner, then round-robin resumes from the owner.
- Memory drive, granted k with addr_k < MEM_DEPTH:
  - mem_addr=addr_k, mem_data_wr=wdata_k, mem_wr_ena=we[k].
- Out of range, addr_k >= MEM_DEPTH:
  - Request is still granted (consumed) with mem_wr_ena=0, no rvalid.
  - err<=1, sticky until reset.
- Read latency:
  - Granted in-range read at cycle T gives rvalid[k]=1 at T+1 for exactly one cycle.
  - rdata=mem_data_rd (pass-through; memory output is registered).
  - rvalid is at most one-hot.
- Back-to-back reads: one result per cycle, in grant order.
- Write followed by a read of the same address on the next cycle returns the new data.
- Reset mid-operation: a pending rvalid is cleared and any lock is dropped.
- Requesters must hold req/we/addr/wdata stable until gnt. Deasserting req before gnt is legal; the request is dropped with no side effects.

Decomposition:
- Shared package fft_mem_pkg:
  - N_REQ=3
  - REQ_LOAD=0, REQ_BFLY=1, REQ_UNLOAD=2
  - MEM_DEPTH, ADDR_WIDTH, DATA_WIDTH defaults
- One sub-module rr_arb3:
  - Combinational round-robin pick from req and rr_ptr, producing a one-hot grant and a 2-bit index.
  - Lock FSM, rvalid pipeline and address check stay in mem_arb.

Test Plan:
- After reset, req=3'b111, all reads to addr 5/6/7 -> gnt order 001, 010, 100 over three cycles; rvalid follows one cycle behind each grant, with rdata equal to the stored words.
- req0 writes 0xDEADBEEF to addr 100 at cycle T, req2 reads addr 100 at T+1 -> rvalid[2] at T+2 with rdata=0xDEADBEEF.
- req1 with lock=1 held, req0 and req2 also asserted -> gnt=010 for exactly 4 consecutive cycles, then 100, then 001.
- req1 locked drops req after 2 cycles -> lock released; next grant goes to round-robin winner after index 1.
- req0 write to addr 2049 -> gnt[0]=1, mem_wr_ena=0, err=1 and stays 1; a subsequent read of addr 2048 works normally.
- rst asserted during a cycle with a read granted -> rvalid, gnt and err go to 0 immediately; after release, first grant of req=3'b111 is requester 0.
